// File: rtl/gate_sweep_checker.sv
// Exhaustive sweep exerciser for an N-input library gate: drives every input vector,
// holds it for SETTLE cycles, samples the gate output and checks it against a reference function.
module gate_sweep_checker #(
  parameter int N      = 2,
  parameter int SETTLE = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   mode,
  output logic [N-1:0] stim,
  input  logic         resp,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic         mode_err,
  output logic [N:0]   err_count,
  output logic [N-1:0] first_fail,
  output logic         first_fail_valid
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SETTLE - 1);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [N-1:0]  STIM_LAST = {N{1'b1}};
  localparam logic [N-1:0]  STIM_ZERO = {N{1'b0}};
  localparam logic [N-1:0]  STIM_ONE  = N'(1);
  localparam logic [N:0]    ERR_ZERO  = {(N+1){1'b0}};
  localparam logic [N:0]    ERR_ONE   = (N+1)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  // Reference function reduced over the whole vector; a single bit reduces to itself.
  function automatic logic ref_bit(input logic [2:0] m, input logic [N-1:0] v);
    logic r;
    case (m)
      3'b000:  r = &v;
      3'b001:  r = |v;
      3'b010:  r = ~&v;
      3'b011:  r = ~|v;
      3'b100:  r = ^v;
      3'b101:  r = ~^v;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  state_e        state_q, state_d;
  logic [2:0]    mode_q, mode_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  stim_q, stim_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic          mode_err_q, mode_err_d;
  logic [N:0]    err_count_q, err_count_d;
  logic [N-1:0]  first_fail_q, first_fail_d;
  logic          first_fail_valid_q, first_fail_valid_d;
  logic          mismatch_s;

  // Next-state and next-output computation for the sweep controller.
  always_comb begin
    state_d            = state_q;
    mode_d             = mode_q;
    cnt_d              = cnt_q;
    stim_d             = stim_q;
    busy_d             = busy_q;
    done_d             = 1'b0;
    pass_d             = pass_q;
    mode_err_d         = mode_err_q;
    err_count_d        = err_count_q;
    first_fail_d       = first_fail_q;
    first_fail_valid_d = first_fail_valid_q;
    mismatch_s         = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          err_count_d        = ERR_ZERO;
          pass_d             = 1'b0;
          first_fail_valid_d = 1'b0;
          if (mode < 3'd6) begin
            state_d    = RUN;
            mode_d     = mode;
            cnt_d      = CNT_ZERO;
            stim_d     = STIM_ZERO;
            busy_d     = 1'b1;
            mode_err_d = 1'b0;
          end else begin
            // Reserved function: report it through FIN without driving any vector.
            state_d    = FIN;
            done_d     = 1'b1;
            mode_err_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        if (cnt_q == CNT_LAST) begin
          mismatch_s = (resp != ref_bit(mode_q, stim_q));
          if (mismatch_s) begin
            err_count_d = err_count_q + ERR_ONE;
            if (!first_fail_valid_q) begin
              first_fail_d       = stim_q;
              first_fail_valid_d = 1'b1;
            end else begin
              first_fail_d       = first_fail_q;
              first_fail_valid_d = first_fail_valid_q;
            end
          end else begin
            err_count_d = err_count_q;
          end
          if (stim_q == STIM_LAST) begin
            // Verdict must include the compare happening on this very edge.
            state_d = FIN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_count_d == ERR_ZERO) && !mode_err_q;
          end else begin
            stim_d = stim_q + STIM_ONE;
            cnt_d  = CNT_ZERO;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= IDLE;
      mode_q             <= 3'b000;
      cnt_q              <= CNT_ZERO;
      stim_q             <= STIM_ZERO;
      busy_q             <= 1'b0;
      done_q             <= 1'b0;
      pass_q             <= 1'b0;
      mode_err_q         <= 1'b0;
      err_count_q        <= ERR_ZERO;
      first_fail_q       <= STIM_ZERO;
      first_fail_valid_q <= 1'b0;
    end else begin
      state_q            <= state_d;
      mode_q             <= mode_d;
      cnt_q              <= cnt_d;
      stim_q             <= stim_d;
      busy_q             <= busy_d;
      done_q             <= done_d;
      pass_q             <= pass_d;
      mode_err_q         <= mode_err_d;
      err_count_q        <= err_count_d;
      first_fail_q       <= first_fail_d;
      first_fail_valid_q <= first_fail_valid_d;
    end
  end

  assign stim             = stim_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign mode_err         = mode_err_q;
  assign err_count        = err_count_q;
  assign first_fail       = first_fail_q;
  assign first_fail_valid = first_fail_valid_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Scoreboard bench for gate_sweep_checker: three instances (N=2/SETTLE=8, N=2/SETTLE=4,
// N=3/SETTLE=2) each driving a behavioural gate model; expectations are queued at start.
module tb_gate_sweep_checker;

  typedef struct {
    logic pass;
    logic merr;
    int   err;
    logic err_min;
    logic ffv;
    int   ff;
    int   done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  always #5 clk = ~clk;

  // Cycle counter: value seen at a negedge is the number of rising edges so far.
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: N=2, SETTLE=8
  logic       start_a = 1'b0;
  logic [2:0] mode_a  = 3'b000;
  logic [1:0] stim_a, ff_a;
  logic       resp_a, busy_a, done_a, pass_a, merr_a, ffv_a;
  logic [2:0] err_a;
  int         gm_a = 2;
  logic [15:0] hist_a = 16'h0000;

  // Instance B: N=2, SETTLE=4, gate under test is NOR
  logic       start_b = 1'b0;
  logic [2:0] mode_b  = 3'b000;
  logic [1:0] stim_b, ff_b;
  logic       resp_b, busy_b, done_b, pass_b, merr_b, ffv_b;
  logic [2:0] err_b;

  // Instance C: N=3, SETTLE=2
  logic       start_c = 1'b0;
  logic [2:0] mode_c  = 3'b000;
  logic [2:0] stim_c, ff_c;
  logic       resp_c, busy_c, done_c, pass_c, merr_c, ffv_c;
  logic [3:0] err_c;
  int         gm_c = 0;

  gate_sweep_checker #(.N(2), .SETTLE(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .mode(mode_a), .stim(stim_a), .resp(resp_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .mode_err(merr_a), .err_count(err_a),
    .first_fail(ff_a), .first_fail_valid(ffv_a));

  gate_sweep_checker #(.N(2), .SETTLE(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .mode(mode_b), .stim(stim_b), .resp(resp_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .mode_err(merr_b), .err_count(err_b),
    .first_fail(ff_b), .first_fail_valid(ffv_b));

  gate_sweep_checker #(.N(3), .SETTLE(2)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .mode(mode_c), .stim(stim_c), .resp(resp_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .mode_err(merr_c), .err_count(err_c),
    .first_fail(ff_c), .first_fail_valid(ffv_c));

  // History of the ideal AND output; hist_a[k] is the ideal value k+1 cycles ago.
  always @(posedge clk) hist_a <= {hist_a[14:0], &stim_a};

  // Gate models: 5/7-cycle rise/fall AND, 9-cycle delayed AND, ideal AND.
  always_comb begin
    case (gm_a)
      0:       resp_a = hist_a[4] | hist_a[6];
      1:       resp_a = hist_a[8];
      default: resp_a = &stim_a;
    endcase
  end

  assign resp_b = ~|stim_b;

  always_comb begin
    case (gm_c)
      0:       resp_c = |stim_c;
      1:       resp_c = ~&stim_c;
      default: resp_c = ~^stim_c;
    endcase
  end

  task automatic check(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic p, input logic me, input int e, input logic emin,
                              input logic fv, input int f);
    exp_t x;
    x.pass = p; x.merr = me; x.err = e; x.err_min = emin; x.ffv = fv; x.ff = f;
    x.done_cyc = 0;
    return x;
  endfunction

  task automatic compare(input string tag, input exp_t e, input logic p, input logic me,
                         input int err, input logic fv, input int f);
    check({tag, "_pass"}, p, e.pass);
    check({tag, "_mode_err"}, me, e.merr);
    if (e.err_min) check({tag, "_err_atleast1"}, (err >= 1) ? 1 : 0, 1);
    else check({tag, "_err_count"}, err, e.err);
    check({tag, "_ffv"}, fv, e.ffv);
    if (e.ffv) check({tag, "_first_fail"}, f, e.ff);
    check({tag, "_done_cycle"}, cyc, e.done_cyc);
  endtask

  // Monitors: every done pulse pops the oldest expectation for that instance.
  always @(negedge clk) begin
    if (done_a) begin
      if (q_a.size() == 0) check("A_unexpected_done", done_a, 0);
      else compare("A", q_a.pop_front(), pass_a, merr_a, int'(err_a), ffv_a, int'(ff_a));
    end
    if (done_b) begin
      if (q_b.size() == 0) check("B_unexpected_done", done_b, 0);
      else compare("B", q_b.pop_front(), pass_b, merr_b, int'(err_b), ffv_b, int'(ff_b));
    end
    if (done_c) begin
      if (q_c.size() == 0) check("C_unexpected_done", done_c, 0);
      else compare("C", q_c.pop_front(), pass_c, merr_c, int'(err_c), ffv_c, int'(ff_c));
    end
  end

  function automatic logic get_done(input int sel);
    return (sel == 0) ? done_a : ((sel == 1) ? done_b : done_c);
  endfunction

  // Pulse start for one cycle and queue the expectation; lat = edges from start to done.
  task automatic issue(input int sel, input logic [2:0] m, input exp_t e, input int lat);
    @(negedge clk);
    e.done_cyc = cyc + 1 + lat;
    case (sel)
      0: begin start_a = 1'b1; mode_a = m; q_a.push_back(e); end
      1: begin start_b = 1'b1; mode_b = m; q_b.push_back(e); end
      default: begin start_c = 1'b1; mode_c = m; q_c.push_back(e); end
    endcase
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
  endtask

  // Returns at the negedge where done is seen, or records a timeout.
  task automatic wait_done(input int sel, input int bound, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      if (get_done(sel)) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) check({tag, "_timeout"}, get_done(sel), 1);
  endtask

  initial begin
    int done_cnt;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("A_rst_stim", stim_a, 0);   check("A_rst_busy", busy_a, 0);
    check("A_rst_done", done_a, 0);   check("A_rst_pass", pass_a, 0);
    check("A_rst_merr", merr_a, 0);   check("A_rst_err", err_a, 0);
    check("A_rst_ff", ff_a, 0);       check("A_rst_ffv", ffv_a, 0);
    check("B_rst_busy", busy_b, 0);   check("B_rst_err", err_b, 0);
    check("C_rst_stim", stim_c, 0);   check("C_rst_pass", pass_c, 0);

    // AND with 5/7 rise/fall delay settles inside 8 cycles.
    gm_a = 0;
    issue(0, 3'b000, mk(1'b1, 1'b0, 0, 1'b0, 1'b0, 0), 32);
    check("A_busy_after_start", busy_a, 1);
    check("A_first_vector", stim_a, 0);
    repeat (8) @(negedge clk);
    check("A_second_vector", stim_a, 1);
    wait_done(0, 60, "A_t1");

    // Reserved mode on B: straight to FIN, never busy, stim untouched.
    @(negedge clk);
    start_b = 1'b1; mode_b = 3'b110;
    begin
      exp_t e = mk(1'b0, 1'b1, 0, 1'b0, 1'b0, 0);
      e.done_cyc = cyc + 1;
      q_b.push_back(e);
    end
    @(negedge clk);
    start_b = 1'b0;
    check("B_resv_busy", busy_b, 0);
    check("B_resv_stim", stim_b, 0);
    @(negedge clk);
    check("B_resv_busy2", busy_b, 0);
    check("B_resv_single_pulse", done_b, 0);

    // XOR reference against a NOR gate: vectors 0,1,2 mismatch.
    issue(1, 3'b100, mk(1'b0, 1'b0, 3, 1'b0, 1'b1, 0), 16);
    repeat (4) @(negedge clk);
    check("B_mid_err_count", err_b, 1);
    check("B_mid_ffv", ffv_b, 1);
    wait_done(1, 40, "B_xor");

    // AND with 9-cycle delay is not settled at the sample edge.
    gm_a = 1;
    issue(0, 3'b000, mk(1'b0, 1'b0, 0, 1'b1, 1'b1, 0), 32);
    wait_done(0, 60, "A_slow");

    // N=3 back-to-back sweeps, each start in the first IDLE cycle after done.
    gm_c = 0;
    issue(2, 3'b001, mk(1'b1, 1'b0, 0, 1'b0, 1'b0, 0), 16);
    wait_done(2, 40, "C_or");
    gm_c = 1;
    issue(2, 3'b010, mk(1'b1, 1'b0, 0, 1'b0, 1'b0, 0), 16);
    wait_done(2, 40, "C_nand");
    gm_c = 2;
    issue(2, 3'b101, mk(1'b1, 1'b0, 0, 1'b0, 1'b0, 0), 16);
    wait_done(2, 40, "C_xnor");

    // Abort a sweep with reset at cycle 10.
    gm_a = 2;
    issue(0, 3'b000, mk(1'b1, 1'b0, 0, 1'b0, 1'b0, 0), 32);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q_a.delete();
    check("A_abort_stim", stim_a, 0);   check("A_abort_busy", busy_a, 0);
    check("A_abort_done", done_a, 0);   check("A_abort_pass", pass_a, 0);
    check("A_abort_merr", merr_a, 0);   check("A_abort_err", err_a, 0);
    check("A_abort_ff", ff_a, 0);       check("A_abort_ffv", ffv_a, 0);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_a) done_cnt++;
    end
    check("A_abort_no_done", done_cnt, 0);

    // start held high and mode wandering after the accepting edge.
    @(negedge clk);
    start_a = 1'b1; mode_a = 3'b000;
    begin
      exp_t e = mk(1'b1, 1'b0, 0, 1'b0, 1'b0, 0);
      e.done_cyc = cyc + 1 + 32;
      q_a.push_back(e);
    end
    @(negedge clk);
    mode_a = 3'b001;
    repeat (10) @(negedge clk);
    mode_a = 3'b110;
    wait_done(0, 60, "A_held");
    start_a = 1'b0;
    mode_a = 3'b000;

    repeat (5) @(negedge clk);
    check("A_queue_drained", q_a.size(), 0);
    check("B_queue_drained", q_b.size(), 0);
    check("C_queue_drained", q_c.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gate_sweep_checker.md
# gate_sweep_checker

Synthesisable, self-checking exerciser for the basic-gate library. It generalises the fixed two-input stimulus sequence to N inputs and six gate functions. On a start command it drives every input combination of an N-input gate under test in ascending order and holds each vector for a programmable settle window, so that gates with non-unit propagation delays resolve. It samples the gate output at the end of each window and compares it against the selected reference function, reporting the mismatch count and the first failing vector. It sits between the clocked test harness and an instantiated library gate.

## Interface
- N, default 2: gate input count; legal range 1..8.
- SETTLE, default 8: cycles each vector is held before its response is sampled; legal range 1..255.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  starts a sweep; accepted only in IDLE.
- mode  in  3  reference function: 000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR, 101 XNOR, 110/111 reserved.
- stim  out  N  vector driven to the inputs of the gate under test.
- resp  in  1  output of the gate under test.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse when a sweep ends.
- pass  out  1  1 when the last sweep had zero mismatches and a legal mode; held until the next accepted start.
- mode_err  out  1  1 when the last start carried a reserved mode; held until the next accepted start.
- err_count  out  N+1  mismatch count of the last or current sweep; maximum 2^N, so it never overflows.
- first_fail  out  N  stim value of the first mismatch.
- first_fail_valid  out  1  first_fail holds a valid value.

## Operation
- FSM states: IDLE, RUN, FIN.
- IDLE -> RUN: on start=1 with a legal mode. On that edge:
  - mode is latched;
  - stim, err_count, the settle counter, pass, mode_err and first_fail_valid are cleared.
- IDLE -> FIN: on start=1 with a reserved mode. On that edge mode_err is set to 1, pass to 0 and err_count to 0. No vectors are driven.
- RUN behaviour:
  - The settle counter counts 0..SETTLE-1 for each vector.
  - On the edge where the counter equals SETTLE-1, resp is compared with the expected value, computed as the latched function reduced over stim.
  - On a mismatch, err_count increments. If first_fail_valid is 0, first_fail takes the current stim and first_fail_valid is set.
  - After that compare, if stim equals 2^N-1 the FSM goes to FIN. Otherwise stim increments and the counter returns to 0.
- FIN -> IDLE unconditionally after one cycle. On entry to FIN, pass is set to (err_count_final==0 && !mode_err). That value includes the last compare.
- The mode input is ignored outside the start edge.
- start while busy=1 or in FIN is ignored.
- With N=1 the "reduction" is the single bit. Inverted modes return its complement.

## Timing
- Reset values: stim=0, busy=0, done=0, pass=0, mode_err=0, err_count=0, first_fail=0, first_fail_valid=0, FSM=IDLE.
- rst asserted during RUN aborts the sweep. Every output takes its reset value on that edge, and no done pulse is produced.
- Signal timing during a sweep:
  - busy is 1 from the cycle after the start edge through the last RUN cycle.
  - done equals (state==FIN), giving a single-cycle pulse.
- Vector v is on stim for exactly SETTLE cycles. resp must be stable by the final edge of that window; that edge samples it.
- Sweep latency: the first vector appears the cycle after start, and done is asserted 2^N·SETTLE cycles after the start edge.
- Back-to-back sweeps: start is accepted in the cycle after done at the earliest, that is, in the first IDLE cycle.
- err_count and first_fail update on the sample edge and are visible the following cycle. They are valid mid-sweep.

## Test plan
- N=2, SETTLE=8, mode=000, ideal AND with a 5/7-cycle rise/fall delay model on resp: stim sequence 0,1,2,3, each held 8 cycles. done 32 cycles after start; pass=1, err_count=0, first_fail_valid=0.
- N=2, SETTLE=4, mode=100, gate under test is NOR: XOR={0,1,1,0} vs NOR={1,0,0,0} gives 3 mismatches (vectors 0,1,2). Required: err_count=3, first_fail=0, first_fail_valid=1, pass=0.
- N=2, SETTLE=8, mode=000, AND gate with 9-cycle delay: response is not settled at the sample. Required: err_count≥1 and pass=0.
- N=3, SETTLE=2, modes 001, 010, 101 each driven against the matching ideal gate: pass=1 each time; done 16 cycles after each start; three sweeps run back to back with start issued in the cycle after done.
- mode=110 on start: FIN next cycle; done pulse; mode_err=1, pass=0, busy never 1, stim stays 0.
- Assert rst at cycle 10 of an N=2, SETTLE=8 sweep: all outputs return to reset values, and no done pulse occurs. Assert start with start/mode held throughout: start is ignored while busy, mode changes are ignored, and a clean sweep still produces pass=1.
